// File: rtl/dcm_prog_pkg.sv
// Shared types and constants for the DCM_CLKGEN programming controller.
package dcm_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_GAP1,
    ST_LOAD_M,
    ST_GAP2,
    ST_GO,
    ST_WAIT_LOW,
    ST_WAIT_HIGH
  } state_e;

  // Command prefixes, shifted out LSB first ahead of the field value
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  function automatic int unsigned field_len(input int unsigned md_w);
    return md_w + 2;
  endfunction

endpackage

// File: rtl/dcm_prog_shifter.sv
// Loadable LSB-first shift register with a length counter; reused for the D and M fields.
module dcm_prog_shifter
  import dcm_prog_pkg::*;
#(
  parameter  int unsigned MD_W = 8,
  localparam int unsigned FL   = field_len(MD_W),
  localparam int unsigned CW   = $clog2(MD_W + 3)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_shift,
  input  logic [FL-1:0] i_data,
  output logic          o_bit,
  output logic          o_last_c
);

  logic [FL-1:0] r_sr;
  logic [CW-1:0] r_cnt;

  // Zeros shift in, so the register is empty once a field has been sent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_cnt <= CW'(FL - 1);
    end else if (i_shift) begin
      r_sr <= {1'b0, r_sr[FL-1:1]};
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_bit    = r_sr[0];
  assign o_last_c = (r_cnt == '0);

endmodule

// File: rtl/dcm_prog_ctl.sv
// Serialises host M/D requests into the DCM_CLKGEN PROGEN/PROGDATA protocol
// and tracks PROGDONE completion with a timeout.
module dcm_prog_ctl
  import dcm_prog_pkg::*;
#(
  parameter int unsigned MD_W           = 8,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [MD_W-1:0] req_m,
  input  logic [MD_W-1:0] req_d,
  output logic            busy,
  output logic            prog_en,
  output logic            prog_data,
  input  logic            prog_done,
  output logic            done,
  output logic            timeout_err,
  output logic [MD_W-1:0] cur_m,
  output logic [MD_W-1:0] cur_d
);

  localparam int unsigned FL = field_len(MD_W);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  state_e          r_state, w_state_nxt;
  logic [GW-1:0]   r_gap;
  logic [TO_W-1:0] r_to_cnt;
  logic [MD_W-1:0] r_wm, r_wd, r_pend_m, r_pend_d, r_cur_m, r_cur_d;
  logic            r_pend_valid, r_busy, r_prog_en, r_done, r_timeout_err;

  logic            w_try, w_launch, w_finish_ok, w_finish_to, w_gap_load;
  logic            w_sh_load, w_sh_shift, w_sh_bit, w_sh_last, w_prog_en_nxt;
  logic [FL-1:0]   w_sh_din;
  logic [MD_W-1:0] w_ld_m, w_ld_d;
  logic [TO_W-1:0] w_to_inc;
  logic            w_to_hit, w_gap_zero;

  // A fresh request beats the queued one (last wins)
  assign w_ld_m     = req_valid ? req_m : r_pend_m;
  assign w_ld_d     = req_valid ? req_d : r_pend_d;
  assign w_to_inc   = r_to_cnt + TO_W'(1);
  assign w_to_hit   = (w_to_inc == TO_W'(TIMEOUT_CYCLES));
  assign w_gap_zero = (r_gap == '0);

  dcm_prog_shifter #(.MD_W(MD_W)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_sh_load),
    .i_shift  (w_sh_shift),
    .i_data   (w_sh_din),
    .o_bit    (w_sh_bit),
    .o_last_c (w_sh_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_try         = 1'b0;
    w_launch      = 1'b0;
    w_finish_ok   = 1'b0;
    w_finish_to   = 1'b0;
    w_gap_load    = 1'b0;
    w_sh_load     = 1'b0;
    w_sh_shift    = 1'b0;
    w_sh_din      = '0;
    w_prog_en_nxt = 1'b0;
    case (r_state)
      ST_IDLE: w_try = 1'b1;
      ST_LOAD_D: begin
        w_sh_shift = 1'b1;
        if (w_sh_last) begin
          w_state_nxt = ST_GAP1;
          w_gap_load  = 1'b1;
        end else begin
          w_prog_en_nxt = 1'b1;
        end
      end
      ST_GAP1: begin
        if (w_gap_zero) begin
          w_state_nxt   = ST_LOAD_M;
          w_sh_load     = 1'b1;
          w_sh_din      = {r_wm, CMD_LOAD_M};
          w_prog_en_nxt = 1'b1;
        end
      end
      ST_LOAD_M: begin
        w_sh_shift = 1'b1;
        if (w_sh_last) begin
          w_state_nxt = ST_GAP2;
          w_gap_load  = 1'b1;
        end else begin
          w_prog_en_nxt = 1'b1;
        end
      end
      ST_GAP2: begin
        if (w_gap_zero) begin
          w_state_nxt   = ST_GO;
          w_prog_en_nxt = 1'b1;
        end
      end
      ST_GO: w_state_nxt = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (w_to_hit) begin
          w_finish_to = 1'b1;
          w_try       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!prog_done) begin
          w_state_nxt = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (prog_done) begin
          w_finish_ok = 1'b1;
          w_try       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_to_hit) begin
          w_finish_to = 1'b1;
          w_try       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Launch straight out of IDLE or a finishing wait so busy never gaps
    if (w_try && (req_valid || r_pend_valid)) begin
      w_state_nxt   = ST_LOAD_D;
      w_launch      = 1'b1;
      w_sh_load     = 1'b1;
      w_sh_din      = {w_ld_d, CMD_LOAD_D};
      w_prog_en_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap         <= '0;
      r_to_cnt      <= '0;
      r_wm          <= '0;
      r_wd          <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_m      <= '0;
      r_pend_d      <= '0;
      r_cur_m       <= '0;
      r_cur_d       <= '0;
      r_busy        <= 1'b0;
      r_prog_en     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_prog_en <= w_prog_en_nxt;
      r_done    <= w_finish_ok;
      if (w_gap_load)
        r_gap <= GW'(GAP_CYCLES - 1);
      else if ((r_state == ST_GAP1 || r_state == ST_GAP2) && !w_gap_zero)
        r_gap <= r_gap - GW'(1);
      if (r_state == ST_GO)
        r_to_cnt <= '0;
      else if (r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH)
        r_to_cnt <= w_to_inc;
      if (w_launch) begin
        r_wm         <= w_ld_m;
        r_wd         <= w_ld_d;
        r_pend_valid <= 1'b0;
      end else if (req_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_m     <= req_m;
        r_pend_d     <= req_d;
      end
      if (w_finish_ok) begin
        r_cur_m <= r_wm;
        r_cur_d <= r_wd;
      end
      // A timeout coinciding with a launch stays visible
      if (w_finish_to)   r_timeout_err <= 1'b1;
      else if (w_launch) r_timeout_err <= 1'b0;
    end
  end

  assign busy        = r_busy;
  assign prog_en     = r_prog_en;
  assign prog_data   = w_sh_bit;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;
  assign cur_m       = r_cur_m;
  assign cur_d       = r_cur_d;

endmodule

// File: tb/tb_dcm_prog_ctl.sv
// Directed bench for dcm_prog_ctl: default geometry (short timeout) plus a wide-field instance.
module tb_dcm_prog_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, prog_done;
  logic [7:0] req_m, req_d;
  logic       busy, prog_en, prog_data, done, timeout_err;
  logic [7:0] cur_m, cur_d;

  logic       w_req_valid, w_prog_done;
  logic [9:0] w_req_m, w_req_d;
  logic       w_busy, w_prog_en, w_prog_data, w_done, w_timeout_err;
  logic [9:0] w_cur_m, w_cur_d;

  logic [63:0] en_v, dat_v, bsy_v, wen_v, wdat_v;
  int          idx;
  int          n_asserts = 0;
  int          n_fail    = 0;

  always #5 clk = ~clk;

  dcm_prog_ctl #(.MD_W(8), .GAP_CYCLES(2), .TIMEOUT_CYCLES(100), .TO_W(16)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_m(req_m), .req_d(req_d),
    .busy(busy), .prog_en(prog_en), .prog_data(prog_data), .prog_done(prog_done),
    .done(done), .timeout_err(timeout_err), .cur_m(cur_m), .cur_d(cur_d)
  );

  dcm_prog_ctl #(.MD_W(10), .GAP_CYCLES(3), .TIMEOUT_CYCLES(100), .TO_W(16)) u_dut_w (
    .clk(clk), .reset(reset), .req_valid(w_req_valid), .req_m(w_req_m), .req_d(w_req_d),
    .busy(w_busy), .prog_en(w_prog_en), .prog_data(w_prog_data), .prog_done(w_prog_done),
    .done(w_done), .timeout_err(w_timeout_err), .cur_m(w_cur_m), .cur_d(w_cur_d)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic rec();
    en_v[6'(idx)]  = prog_en;
    dat_v[6'(idx)] = prog_data;
    bsy_v[6'(idx)] = busy;
    idx++;
  endtask

  task automatic clr_rec();
    idx   = 0;
    en_v  = '0;
    dat_v = '0;
    bsy_v = '0;
  endtask

  task automatic sample(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
      rec();
    end
  endtask

  task automatic put_req(input logic [7:0] m, input logic [7:0] d);
    req_valid = 1'b1;
    req_m     = m;
    req_d     = d;
  endtask

  // DCM model: PROGDONE drops 3 cycles after GO and rises 20 cycles later
  task automatic wait_done(input string tag, input logic exp_busy,
                           input logic [7:0] em, input logic [7:0] ed);
    int lat;
    lat = 0;
    repeat (3) @(negedge clk);
    prog_done = 1'b0;
    repeat (20) @(negedge clk);
    prog_done = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 8);
    chk({tag, "_done_lat"}, 64'(lat), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    chk({tag, "_cur"}, 64'({cur_m, cur_d}), 64'({em, ed}));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int first_to;
    logic seen_done;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_m       = '0;
    req_d       = '0;
    prog_done   = 1'b1;
    w_req_valid = 1'b0;
    w_req_m     = '0;
    w_req_d     = '0;
    w_prog_done = 1'b1;
    clr_rec();
    repeat (3) @(negedge clk);
    chk("reset_out", 64'({busy, prog_en, prog_data, done, timeout_err, cur_m, cur_d}), 64'd0);
    chk("reset_out_w", 64'({w_busy, w_prog_en, w_prog_data, w_done, w_timeout_err, w_cur_m, w_cur_d}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic sequence M=0x05 D=0x03
    clr_rec();
    put_req(8'h05, 8'h03);
    sample(25);
    chk("t1_en", en_v, 64'h13FF3FF);
    chk("t1_data", dat_v, 64'h1700D);
    chk("t1_busy", bsy_v, 64'h1FFFFFF);
    wait_done("t1", 1'b0, 8'h05, 8'h03);
    @(negedge clk);
    chk("t1_done_width", 64'(done), 64'd0);

    // Two requests during LOAD_M: only the later one is programmed next
    clr_rec();
    put_req(8'h05, 8'h03);
    sample(14);
    put_req(8'h10, 8'h02);
    sample(2);
    put_req(8'h20, 8'h04);
    sample(9);
    chk("t2a_en", en_v, 64'h13FF3FF);
    chk("t2a_data", dat_v, 64'h1700D);
    wait_done("t2a", 1'b1, 8'h05, 8'h03);
    clr_rec();
    rec();
    sample(24);
    chk("t2b_en", en_v, 64'h13FF3FF);
    chk("t2b_data", dat_v, 64'h83011);
    chk("t2b_busy", bsy_v, 64'h1FFFFFF);
    wait_done("t2b", 1'b0, 8'h20, 8'h04);
    repeat (5) @(negedge clk);
    chk("t2_idle", 64'({busy, prog_en}), 64'd0);

    // PROGDONE stuck high: timeout after 100 cycles in the wait states
    clr_rec();
    put_req(8'h11, 8'h22);
    sample(25);
    first_to  = -1;
    seen_done = 1'b0;
    for (int i = 0; i < 150 && first_to < 0; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (timeout_err) first_to = i;
    end
    chk("t3_to_cycle", 64'(first_to), 64'd100);
    chk("t3_no_done", 64'(seen_done), 64'd0);
    chk("t3_cur_kept", 64'({cur_m, cur_d}), 64'h2004);
    chk("t3_busy", 64'(busy), 64'd0);

    // Next launch clears the error; then reset in cycle 5 of LOAD_D
    put_req(8'h05, 8'h03);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t4_err_clr", 64'({busy, timeout_err}), 64'h2);
    repeat (4) @(negedge clk);
    chk("t4_pre_en", 64'(prog_en), 64'd1);
    #2 reset = 1'b1;
    #1 chk("t4_async", 64'({busy, prog_en, prog_data, done, timeout_err, cur_m, cur_d}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clr_rec();
    put_req(8'h05, 8'h03);
    sample(25);
    chk("t4_en", en_v, 64'h13FF3FF);
    chk("t4_data", dat_v, 64'h1700D);

    // Wide instance: 12-cycle fields, 3-cycle gaps, GO at launch+30
    wen_v  = '0;
    wdat_v = '0;
    w_req_valid = 1'b1;
    w_req_m     = 10'h3FF;
    w_req_d     = 10'h001;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      w_req_valid = 1'b0;
      wen_v[6'(i)]  = w_prog_en;
      wdat_v[6'(i)] = w_prog_data;
    end
    chk("t5_en", wen_v, 64'h47FF8FFF);
    chk("t5_data", wdat_v, 64'h7FF8005);
    chk("t5_busy", 64'(w_busy), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/dcm_prog_ctl.md
Name: dcm_prog_ctl

Overview:
- Parametrised successor to the inline clock-frequency programming shift register: serialises a host M/D request into the DCM_CLKGEN PROGEN/PROGDATA protocol.
- Adds request handshake, queued last-wins pending request, and PROGDONE completion tracking with timeout.
- Reports applied M/D and error status.
- Sits in the board top level on the 100 MHz programming clock, between the bruteforcer's frequency-control output and the programmable core PLL.

Parameters:
- MD_W, 8, width of the M and D fields; values are the raw register values (already minus one).
- GAP_CYCLES, 2, idle cycles with prog_en=0 between LOAD_D, LOAD_M and GO.
- TIMEOUT_CYCLES, 65535, maximum cycles in WAIT_DONE before abort.
- TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  programming clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request strobe, single cycle or held.
- req_m  in  MD_W  requested M value.
- req_d  in  MD_W  requested D value.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- prog_en  out  1  PROGEN to DCM, registered.
- prog_data  out  1  PROGDATA to DCM, registered.
- prog_done  in  1  PROGDONE from DCM (same clock domain).
- done  out  1  one-cycle pulse on successful completion.
- timeout_err  out  1  sticky; cleared when the next request is launched.
- cur_m  out  MD_W  last successfully applied M.
- cur_d  out  MD_W  last successfully applied D.

Behaviour:
- Reset: every output is 0, state is IDLE, and there is no pending request.
- Acceptance:
  - A request with req_valid=1 is always accepted.
  - In IDLE it launches on the next cycle.
  - Otherwise it overwrites the single pending slot (last wins).
- Launch: on entering LOAD_D, latch M/D into working registers, set busy=1 and clear timeout_err.
- States:
  - IDLE.
  - LOAD_D: MD_W+2 cycles with prog_en=1. prog_data = 1, 0, then D LSB first.
  - GAP1: GAP_CYCLES cycles, prog_en=0, prog_data=0.
  - LOAD_M: MD_W+2 cycles with prog_en=1. prog_data = 1, 1, then M LSB first.
  - GAP2: GAP_CYCLES cycles, prog_en=0.
  - GO: 1 cycle, prog_en=1, prog_data=0.
  - WAIT_LOW: waits for prog_done=0.
  - WAIT_HIGH: waits for prog_done=1.
- Bit-serial length counter: $clog2(MD_W+3) bits, reloaded at each field start.
- Timeout counter:
  - Starts at 0 on entering WAIT_LOW and runs continuously through WAIT_LOW and WAIT_HIGH.
  - At count == TIMEOUT_CYCLES: set timeout_err=1, leave cur_m/cur_d unchanged, no done pulse, go to IDLE.
- Completion: when prog_done=1 in WAIT_HIGH, on the next edge pulse done, load cur_m/cur_d from the working registers, and go to IDLE.
- Pending request on IDLE entry: if the pending slot is valid, launch it immediately. busy stays high with no IDLE gap cycle visible on busy.
- Simultaneous req_valid on the completion cycle: the new request lands in the pending slot and launches next.
- Reset mid-sequence: prog_en drops to 0 immediately (async). The DCM sees an aborted load, and the next full sequence overrides it.
- Total cycles from launch to GO inclusive: 2*(MD_W+2) + 2*GAP_CYCLES + 1. Default: 25, matching the legacy pattern length.

Decomposition:
- Package dcm_prog_pkg holds:
  - the state enum;
  - command-bit constants CMD_LOAD_D=2'b01 and CMD_LOAD_M=2'b11, both shifted LSB first;
  - a localparam function for field length.
- One natural sub-module, dcm_prog_shifter: a loadable LSB-first shift register of MD_W+2 bits with a length counter and a last_bit flag. It is instantiated once and reused for both fields.

Test Plan:
- Reset, then req M=0x05, D=0x03:
  - prog_en is 1 for 10 cycles, 0 for 2, 1 for 10, 0 for 2, then 1 for 1.
  - D stream is 1,0,1,1,0,0,0,0,0,0; M stream is 1,1,1,0,1,0,0,0,0,0; GO data is 0.
- Model drops prog_done 3 cycles after GO and raises it 20 cycles later: one done pulse, cur_m=0x05, cur_d=0x03, busy falls the same cycle.
- Issue requests (0x10,0x02) then (0x20,0x04) during LOAD_M of (0x05,0x03): after the first completes, only (0x20,0x04) is programmed, back-to-back with busy held high.
- prog_done held high forever with TIMEOUT_CYCLES=100: timeout_err=1 exactly 100 cycles after WAIT_LOW entry, no done pulse, cur_m/cur_d unchanged; the next request clears timeout_err.
- Assert reset in cycle 5 of LOAD_D: prog_en=0 asynchronously and all outputs 0; a fresh request afterwards produces the full 25-cycle pattern.
- MD_W=10, GAP_CYCLES=3 with M=0x3FF, D=0x001: field lengths are 12 and gaps are 3; GO occurs at launch+30.
